// File: rtl/dff_pkg.sv
// Shared definitions for the D flip-flop response checker.
package dff_pkg;

    // Checker FSM: wait for a known flop state, compare, then hold results.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } dff_mon_state_t;

    localparam int DFF_MON_CNT_W      = 8;
    localparam int DFF_MON_NUM_CHECKS = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    // Count up on inc, stick at all-ones, zero on clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dff_monitor.sv
// Response checker for a D flip-flop: one-register reference model, compare
// counters, sticky error and completion flag.
// Optional macro DFF_MON_FIRST_ERR_EN adds first_err_idx, the check index of
// the first mismatch (all-ones while no mismatch has been seen).
module dff_monitor
    import dff_pkg::*;
#(
    parameter int CNT_W      = DFF_MON_CNT_W,
    parameter int NUM_CHECKS = DFF_MON_NUM_CHECKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             dut_reset,
    input  logic             dut_d,
    input  logic             dut_q,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic             mis_pulse,
    output logic             err,
    output logic             done
`ifdef DFF_MON_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx
`endif
);

    // check_cnt value seen on the compare that completes the run
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);

    dff_mon_state_t state, state_nxt;
    logic           exp_q;
    logic           in_check;
    logic           mismatch;
    logic           last_cmp;

    assign in_check = (state == CHECK);
    assign mismatch = in_check && (dut_q != exp_q);
    assign last_cmp = in_check && (check_cnt == LAST_IDX);
    assign done     = (state == DONE);

    // Next-state: clr always restarts; the model is trusted only after a dut_reset.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (dut_reset) state_nxt = CHECK;
                CHECK:   if (last_cmp)  state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Reference flop model; keeps tracking in every state, including during clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         exp_q <= 1'b0;
        else if (dut_reset) exp_q <= 1'b0;
        else                exp_q <= dut_d;
    end

    // Mismatch pulse and sticky error; clr suppresses a same-edge mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_pulse <= 1'b0;
            err       <= 1'b0;
        end else if (clr) begin
            mis_pulse <= 1'b0;
            err       <= 1'b0;
        end else begin
            mis_pulse <= mismatch;
            if (mismatch) err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_check_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_check),
        .clr   (clr),
        .cnt   (check_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mismatch),
        .clr   (clr),
        .cnt   (mis_cnt)
    );

`ifdef DFF_MON_FIRST_ERR_EN
    // Latch the pre-increment check index of the first mismatch only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            first_err_idx <= '1;
        else if (clr)
            first_err_idx <= '1;
        else if (mismatch && !err)
            first_err_idx <= check_cnt;
    end
`endif

endmodule

// File: tb/tb_dff_monitor.sv
// Directed bench for dff_monitor: behavioural dff with fault hooks, a default
// instance and a narrow CNT_W=3 instance fed an inverted q.
module tb_dff_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       dut_reset = 1'b0;
    logic       dut_d = 1'b0;
    logic       ff_q;
    logic       flip = 1'b0;
    logic       ign_rst = 1'b0;
    logic       dut_q;
    logic       sat_q;

    logic [7:0] check_cnt, mis_cnt;
    logic       mis_pulse, err, done;
    logic [2:0] s_check_cnt, s_mis_cnt;
    logic       s_mis_pulse, s_err, s_done;
`ifdef DFF_MON_FIRST_ERR_EN
    logic [7:0] first_err_idx;
    logic [2:0] s_first_err_idx;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Observed flop model; ign_rst emulates a flop that ignores its reset.
    always @(posedge clk) ff_q <= (dut_reset && !ign_rst) ? 1'b0 : dut_d;

    assign dut_q = ff_q ^ flip;
    assign sat_q = ~ff_q;

    dff_monitor u_dut (
        .clk(clk), .reset(reset), .clr(clr), .dut_reset(dut_reset),
        .dut_d(dut_d), .dut_q(dut_q), .check_cnt(check_cnt), .mis_cnt(mis_cnt),
        .mis_pulse(mis_pulse), .err(err), .done(done)
`ifdef DFF_MON_FIRST_ERR_EN
        , .first_err_idx(first_err_idx)
`endif
    );

    dff_monitor #(.CNT_W(3), .NUM_CHECKS(7)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .dut_reset(dut_reset),
        .dut_d(dut_d), .dut_q(sat_q), .check_cnt(s_check_cnt), .mis_cnt(s_mis_cnt),
        .mis_pulse(s_mis_pulse), .err(s_err), .done(s_done)
`ifdef DFF_MON_FIRST_ERR_EN
        , .first_err_idx(s_first_err_idx)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // clr for one edge, then one dut_reset edge to enter CHECK.
    task automatic restart();
        clr = 1'b1; dut_reset = 1'b0; flip = 1'b0;
        step();
        clr = 1'b0; dut_reset = 1'b1;
        step();
        dut_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        total++; if ({check_cnt, mis_cnt, mis_pulse, err, done} !== 19'd0)
            $display("FAIL reset_outputs got cc=%0d mc=%0d mp=%b err=%b done=%b want all 0",
                     check_cnt, mis_cnt, mis_pulse, err, done); else passed++;
`ifdef DFF_MON_FIRST_ERR_EN
        total++; if (first_err_idx !== 8'hFF)
            $display("FAIL reset_first_err got %0d want 255", first_err_idx); else passed++;
`endif
        reset = 1'b1;
    endtask

    task automatic test_track();
        dut_reset = 1'b1;
        step();  // IDLE -> CHECK
        step();  // compare 1
        dut_reset = 1'b0;
        total++; if (check_cnt !== 8'd1)
            $display("FAIL track_first_cmp got %0d want 1", check_cnt); else passed++;
        for (int i = 0; i < 14; i++) begin
            dut_d = ~dut_d;
            step();
        end
        total++; if (check_cnt !== 8'd15 || done !== 1'b0)
            $display("FAIL track_pre_done got cc=%0d done=%b want 15/0", check_cnt, done); else passed++;
        dut_d = ~dut_d;
        step();
        total++; if (done !== 1'b1 || check_cnt !== 8'd16 || mis_cnt !== 8'd0 || err !== 1'b0)
            $display("FAIL track_done got done=%b cc=%0d mc=%0d err=%b want 1/16/0/0",
                     done, check_cnt, mis_cnt, err); else passed++;
        dut_d = ~dut_d;
        step();
        total++; if (check_cnt !== 8'd16 || done !== 1'b1)
            $display("FAIL done_hold got cc=%0d done=%b want 16/1", check_cnt, done); else passed++;
        // narrow instance saw 7 inverted compares
        total++; if (s_mis_cnt !== 3'd7 || s_err !== 1'b1 || s_done !== 1'b1 || s_check_cnt !== 3'd7)
            $display("FAIL saturation got mc=%0d err=%b done=%b cc=%0d want 7/1/1/7",
                     s_mis_cnt, s_err, s_done, s_check_cnt); else passed++;
    endtask

    task automatic test_fault();
        int pulses = 0;
        int steps = 0;
        restart();
        while (check_cnt != 8'd16 && steps < 40) begin
            flip  = (check_cnt == 8'd3) || (check_cnt == 8'd7);
            dut_d = ~dut_d;
            step();
            steps++;
            if (mis_pulse === 1'b1) pulses++;
        end
        flip = 1'b0;
        total++; if (steps >= 40)
            $display("FAIL fault_timeout got %0d steps want <40", steps); else passed++;
        total++; if (pulses != 2)
            $display("FAIL fault_pulses got %0d want 2", pulses); else passed++;
        total++; if (mis_cnt !== 8'd2 || err !== 1'b1)
            $display("FAIL fault_counts got mc=%0d err=%b want 2/1", mis_cnt, err); else passed++;
`ifdef DFF_MON_FIRST_ERR_EN
        total++; if (first_err_idx !== 8'd3)
            $display("FAIL fault_first_idx got %0d want 3", first_err_idx); else passed++;
`endif
    endtask

    task automatic run_mid_reset(input logic ignore, input logic [7:0] want, input string nm);
        dut_d = 1'b1;
        restart();
        step(); step(); step();
        dut_reset = 1'b1; ign_rst = ignore;
        step();
        dut_reset = 1'b0; ign_rst = 1'b0;
        step(); step(); step(); step();
        total++; if (mis_cnt !== want || check_cnt !== 8'd8)
            $display("FAIL %s got mc=%0d cc=%0d want %0d/8", nm, mis_cnt, check_cnt, want); else passed++;
    endtask

    task automatic test_dut_reset_mid();
        run_mid_reset(1'b0, 8'd0, "midreset_good");
        run_mid_reset(1'b1, 8'd1, "midreset_bad");
    endtask

    task automatic test_clr_vs_mis();
        restart();
        step(); step();
        flip = 1'b1; clr = 1'b1;
        step();
        flip = 1'b0; clr = 1'b0;
        total++; if (err !== 1'b0 || check_cnt !== 8'd0 || mis_cnt !== 8'd0 || mis_pulse !== 1'b0)
            $display("FAIL clr_wins got err=%b cc=%0d mc=%0d mp=%b want 0/0/0/0",
                     err, check_cnt, mis_cnt, mis_pulse); else passed++;
        step(); step();
        total++; if (check_cnt !== 8'd0 || done !== 1'b0)
            $display("FAIL clr_idle got cc=%0d done=%b want 0/0", check_cnt, done); else passed++;
        dut_reset = 1'b1;
        step();
        dut_reset = 1'b0;
        step();
        total++; if (check_cnt !== 8'd1 || err !== 1'b0)
            $display("FAIL clr_restart got cc=%0d err=%b want 1/0", check_cnt, err); else passed++;
    endtask

    task automatic test_async_reset();
        restart();
        flip = 1'b1;
        step();
        flip = 1'b0;
        step(); step(); step(); step();
        total++; if (check_cnt !== 8'd5 || mis_cnt !== 8'd1 || err !== 1'b1)
            $display("FAIL async_pre got cc=%0d mc=%0d err=%b want 5/1/1", check_cnt, mis_cnt, err); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if ({check_cnt, mis_cnt, mis_pulse, err, done} !== 19'd0)
            $display("FAIL async_clear got cc=%0d mc=%0d mp=%b err=%b done=%b want all 0",
                     check_cnt, mis_cnt, mis_pulse, err, done); else passed++;
`ifdef DFF_MON_FIRST_ERR_EN
        total++; if (first_err_idx !== 8'hFF)
            $display("FAIL async_first_err got %0d want 255", first_err_idx); else passed++;
`endif
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_track();
        test_fault();
        test_dut_reset_mid();
        test_clr_vs_mis();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dff_monitor.md
# dff_monitor

Synthesizable response checker for the D flip-flop. It observes the flop's `d`, `reset` and `q` nets and keeps a one-register reference model of the flop. Each cycle it compares the flop's `q` against the model and counts checks and mismatches. It raises a sticky error flag and reports completion after a programmed number of checks. It sits beside a `dff` instance in benches and in on-chip self-test wrappers, so DUT stimulus and response checking stay separate.

## Interface
- `CNT_W`, default 8: width of the check and mismatch counters.
- `NUM_CHECKS`, default 16: number of compares before `done`. Legal range is 1 to 2^CNT_W−1.

Ports:
- `clk`, input, 1: monitor clock. Same clock as the observed flop.
- `reset`, input, 1: monitor reset, asynchronous, active-low.
- `clr`, input, 1: synchronous restart. Returns to IDLE and zeroes counters and `err`.
- `dut_reset`, input, 1: the observed flop's reset. Active-high, synchronous to `clk`.
- `dut_d`, input, 1: the observed flop's data input.
- `dut_q`, input, 1: the observed flop's output.
- `check_cnt`, output, CNT_W: number of compares performed.
- `mis_cnt`, output, CNT_W: number of mismatches. Saturates at all-ones.
- `mis_pulse`, output, 1: one-cycle pulse, registered, for each mismatch.
- `err`, output, 1: sticky, set on the first mismatch.
- `done`, output, 1: high once `check_cnt == NUM_CHECKS`. Holds until `clr` or `reset`.

## Operation
- Reference model: `exp_q` is updated on every `clk` rising edge.
  - `dut_reset` = 1: `exp_q` ← 0.
  - `dut_reset` = 0: `exp_q` ← `dut_d`.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: `exp_q` is not yet trusted. Moves to CHECK on the first edge where `dut_reset` = 1.
  - CHECK: on each edge, compares `dut_q` with `exp_q`.
    - Increments `check_cnt`.
    - On inequality: increments `mis_cnt` (saturating), asserts `mis_pulse` and sets `err`.
    - After the edge that makes `check_cnt == NUM_CHECKS`, moves to DONE.
  - DONE: no compares and no counter changes. `exp_q` keeps tracking.
- `clr` has priority over all state activity:
  - Next state is IDLE.
  - Counters, `err`, `mis_pulse` and `done` are set to 0.
  - `exp_q` still tracks.
- Reset values, `reset` = 0: state IDLE, `exp_q` = 0, `check_cnt` = 0, `mis_cnt` = 0, `mis_pulse` = 0, `err` = 0, `done` = 0.

## Timing
- Compare latency: the `dut_d` value sampled at edge k is checked against `dut_q` at edge k+1. The result shows on `mis_pulse` and the counters after edge k+1.
- `done` rises in the same cycle that `check_cnt` reaches NUM_CHECKS.
- `dut_reset` asserted during CHECK is legal. The model expects `q` = 0 one edge later, and compares continue.
- `reset` asserted mid-run clears all state immediately, without waiting for a clock edge.
- Simultaneous `clr` and mismatch: `clr` wins, so `err` stays 0.
- `mis_cnt` saturation: at 2^CNT_W−1 it holds, while `err` and `mis_pulse` keep behaving normally.

## Configuration
- Macro `DFF_MON_FIRST_ERR_EN`.
- Defined:
  - Adds output `first_err_idx`, CNT_W bits.
  - Captures the `check_cnt` value before the increment on the first mismatch.
  - Holds that value until `clr` or `reset`.
  - Reset value is all-ones, meaning no error.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- The shared package `dff_pkg` holds:
  - the FSM state enum `dff_mon_state_t` (IDLE, CHECK, DONE);
  - default constants `DFF_MON_CNT_W` and `DFF_MON_NUM_CHECKS`.
- One sub-module, `sat_counter` (parameter width; inputs inc and clr; saturating). It is instantiated for `check_cnt` and `mis_cnt`.
- The FSM and the reference model live in `dff_monitor`.

## Test plan
- Reset then track:
  - Stimulus: `reset` low for 2 cycles, `dut_reset` = 1 for 2 cycles, then `dut_d` toggling 0/1, with `dut_q` driven by a correct `dff`.
  - Required: after 16 compares `done` = 1, `check_cnt` = 16, `mis_cnt` = 0, `err` = 0.
- Fault injection:
  - Stimulus: force `dut_q` to the wrong value on compares 3 and 7.
  - Required: `mis_pulse` fires twice, `mis_cnt` = 2, `err` = 1. With `DFF_MON_FIRST_ERR_EN`, `first_err_idx` = 3.
- DUT reset mid-run:
  - Stimulus: `dut_d` = 1 steady, `dut_reset` pulsed high for 1 cycle during CHECK.
  - Required: a correct `dff` gives `mis_cnt` = 0. A `dff` that ignores reset gives `mis_cnt` = 1.
- `clr` versus mismatch:
  - Stimulus: `clr` asserted on the same edge as a mismatch.
  - Required: state IDLE, `err` = 0, counters 0. The next `dut_reset` restarts checking.
- Async reset mid-run:
  - Stimulus: drop `reset` between edges while `check_cnt` = 5.
  - Required: all outputs 0 immediately, with no clock edge.
- Saturation:
  - Stimulus: CNT_W = 3, NUM_CHECKS = 7, `dut_q` inverted throughout.
  - Required: `mis_cnt` = 7, `err` = 1, `done` = 1.
